// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin front end for a single-port
// word memory. One transaction is in flight at a time; reads return
// their data on a per-requester response channel, writes are silent.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; grants one requester combinationally
// ISSUE | single-cycle memory strobe from the captured request
// WAIT  | memory read latency cycle; read data registered at the edge
// RESP  | read response held on the granted channel until taken
module mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  axis_aclk,
  input  logic                  axis_reset,

  input  logic                  rq0_tvalid,
  output logic                  rq0_tready,
  input  logic                  rq0_we,
  input  logic [ADDR_WIDTH-1:0] rq0_addr,
  input  logic [DATA_WIDTH-1:0] rq0_wdata,

  input  logic                  rq1_tvalid,
  output logic                  rq1_tready,
  input  logic                  rq1_we,
  input  logic [ADDR_WIDTH-1:0] rq1_addr,
  input  logic [DATA_WIDTH-1:0] rq1_wdata,

  output logic                  rs0_tvalid,
  input  logic                  rs0_tready,
  output logic [DATA_WIDTH-1:0] rs0_tdata,

  output logic                  rs1_tvalid,
  input  logic                  rs1_tready,
  output logic [DATA_WIDTH-1:0] rs1_tdata,

  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,

  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;

  // Index of the requester granted most recently; reset value makes
  // requester 0 win the first tie.
  logic                  last_grant;

  logic                  accept;
  logic                  grant_idx;

  logic                  cap_we;
  logic                  cap_idx;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [DATA_WIDTH-1:0] rsp_data;

  logic                  rsp_taken;

  // Round-robin grant; ready is withheld while reset is sampled so that
  // nothing is accepted and the ready outputs read 0 during reset.
  always_comb begin
    accept     = 1'b0;
    grant_idx  = 1'b0;
    rq0_tready = 1'b0;
    rq1_tready = 1'b0;
    if (state == IDLE && !axis_reset) begin
      if (rq0_tvalid && rq1_tvalid) begin
        grant_idx = ~last_grant;
      end else if (rq1_tvalid) begin
        grant_idx = 1'b1;
      end else begin
        grant_idx = 1'b0;
      end
      accept     = rq0_tvalid | rq1_tvalid;
      rq0_tready = accept & ~grant_idx;
      rq1_tready = accept & grant_idx;
    end
  end

  // Response handshake on whichever channel owns the transaction.
  always_comb begin
    rsp_taken = 1'b0;
    if (state == RESP) begin
      rsp_taken = cap_idx ? rs1_tready : rs0_tready;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = cap_we ? IDLE : WAIT;
      end
      WAIT: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_taken) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset abandons any transaction in progress.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the granted request and advance the round-robin pointer only
  // when a request is actually accepted.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      last_grant <= 1'b1;
      cap_we     <= 1'b0;
      cap_idx    <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
    end else if (accept) begin
      last_grant <= grant_idx;
      cap_idx    <= grant_idx;
      cap_we     <= grant_idx ? rq1_we    : rq0_we;
      cap_addr   <= grant_idx ? rq1_addr  : rq0_addr;
      cap_wdata  <= grant_idx ? rq1_wdata : rq0_wdata;
    end
  end

  // Register the memory read data at the end of the latency cycle.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      rsp_data <= '0;
    end else if (state == WAIT) begin
      rsp_data <= mem_rd_data;
    end
  end

  // Memory side: strobes, address and write data only during ISSUE so the
  // bus is quiet (all zero) at every other time.
  always_comb begin
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ISSUE) begin
      mem_wr_en = cap_we;
      mem_rd_en = ~cap_we;
      mem_addr  = cap_addr;
      if (cap_we) begin
        mem_wdata = cap_wdata;
      end
    end
  end

  // Response side: only the granted channel shows valid and data.
  always_comb begin
    rs0_tvalid = 1'b0;
    rs1_tvalid = 1'b0;
    rs0_tdata  = '0;
    rs1_tdata  = '0;
    if (state == RESP) begin
      if (cap_idx) begin
        rs1_tvalid = 1'b1;
        rs1_tdata  = rsp_data;
      end else begin
        rs0_tvalid = 1'b1;
        rs0_tdata  = rsp_data;
      end
    end
  end

  // Busy whenever a transaction is in flight.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level reference model of the arbiter.
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          axis_aclk = 1'b0;
  logic          axis_reset;
  logic          rq0_tvalid, rq0_tready, rq0_we;
  logic [AW-1:0] rq0_addr;
  logic [DW-1:0] rq0_wdata;
  logic          rq1_tvalid, rq1_tready, rq1_we;
  logic [AW-1:0] rq1_addr;
  logic [DW-1:0] rq1_wdata;
  logic          rs0_tvalid, rs0_tready;
  logic [DW-1:0] rs0_tdata;
  logic          rs1_tvalid, rs1_tready;
  logic [DW-1:0] rs1_tdata;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rd_data;
  logic          busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 axis_aclk = ~axis_aclk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .axis_aclk   (axis_aclk),
    .axis_reset  (axis_reset),
    .rq0_tvalid  (rq0_tvalid),
    .rq0_tready  (rq0_tready),
    .rq0_we      (rq0_we),
    .rq0_addr    (rq0_addr),
    .rq0_wdata   (rq0_wdata),
    .rq1_tvalid  (rq1_tvalid),
    .rq1_tready  (rq1_tready),
    .rq1_we      (rq1_we),
    .rq1_addr    (rq1_addr),
    .rq1_wdata   (rq1_wdata),
    .rs0_tvalid  (rs0_tvalid),
    .rs0_tready  (rs0_tready),
    .rs0_tdata   (rs0_tdata),
    .rs1_tvalid  (rs1_tvalid),
    .rs1_tready  (rs1_tready),
    .rs1_tdata   (rs1_tdata),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rd_data (mem_rd_data),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    return 32'hC0DE_0000 + 32'(a) * 32'h0001_0001;
  endfunction

  // Memory model: strobes sampled mid-cycle; read data presented from the
  // strobe cycle onward and held until the next read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(i);
    mem_rd_data = '0;
    forever begin
      @(negedge axis_aclk);
      if (mem_wr_en) mem[mem_addr] = mem_wdata;
      if (mem_rd_en) mem_rd_data = mem[mem_addr];
    end
  end

  // Reference model: one transaction record, a cycle counter and the
  // latency rules (strobe 1 cycle after acceptance, response from 3 cycles).
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            cyc = 0;
  int            acc_cyc = 0;
  bit            inflight = 1'b0;
  bit            m_last = 1'b1;
  bit            rst_prev = 1'b0;
  bit            t_we, t_idx;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, t_exp;
  logic [DW-1:0] last_rs0 = '0, last_rs1 = '0;
  int            gq[$];
  logic [1:0]    e_rdy, e_v;
  bit            strobe, rsv;

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
    forever begin
      @(negedge axis_aclk);
      cyc++;
      if (axis_reset) begin
        if (rst_prev) begin
          chk("rst_ctl", {rq1_tready, rq0_tready, mem_wr_en, mem_rd_en, rs0_tvalid, rs1_tvalid, busy}, 0);
          chk("rst_bus", {mem_addr, mem_wdata}, 0);
          chk("rst_rdata", {rs0_tdata, rs1_tdata}, 0);
        end
        rst_prev = 1'b1;
        inflight = 1'b0;
        m_last   = 1'b1;
      end else begin
        rst_prev = 1'b0;
        e_rdy = 2'b00;
        if (!inflight) begin
          if (rq0_tvalid && rq1_tvalid) e_rdy = m_last ? 2'b01 : 2'b10;
          else                          e_rdy = {rq1_tvalid, rq0_tvalid};
        end
        chk("rq_tready", {rq1_tready, rq0_tready}, e_rdy);
        strobe = inflight && (cyc == acc_cyc + 1);
        chk("mem_strobe", {mem_wr_en, mem_rd_en}, strobe ? {t_we, !t_we} : 2'b00);
        chk("mem_addr", mem_addr, strobe ? t_addr : '0);
        chk("mem_wdata", mem_wdata, (strobe && t_we) ? t_wdata : '0);
        rsv = inflight && !t_we && (cyc >= acc_cyc + 3);
        e_v = rsv ? (t_idx ? 2'b10 : 2'b01) : 2'b00;
        chk("rs_tvalid", {rs1_tvalid, rs0_tvalid}, e_v);
        chk("rs0_tdata", rs0_tdata, e_v[0] ? t_exp : '0);
        chk("rs1_tdata", rs1_tdata, e_v[1] ? t_exp : '0);
        chk("busy", busy, inflight);
        if (inflight) begin
          if (t_we && cyc == acc_cyc + 1) begin
            inflight = 1'b0;
          end else if (rsv && (t_idx ? rs1_tready : rs0_tready)) begin
            inflight = 1'b0;
            if (t_idx) last_rs1 = rs1_tdata;
            else       last_rs0 = rs0_tdata;
          end
        end else if (e_rdy != 2'b00) begin
          t_idx    = e_rdy[1];
          t_we     = t_idx ? rq1_we    : rq0_we;
          t_addr   = t_idx ? rq1_addr  : rq0_addr;
          t_wdata  = t_idx ? rq1_wdata : rq0_wdata;
          acc_cyc  = cyc;
          inflight = 1'b1;
          m_last   = t_idx;
          gq.push_back(int'(t_idx));
          if (t_we) ref_mem[t_addr] = t_wdata;
          else      t_exp = ref_mem[t_addr];
        end
      end
    end
  end

  task automatic tick;
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic send(input bit idx, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 1'b0;
    if (!idx) begin
      rq0_tvalid = 1'b1; rq0_we = we; rq0_addr = a; rq0_wdata = d;
    end else begin
      rq1_tvalid = 1'b1; rq1_we = we; rq1_addr = a; rq1_wdata = d;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge axis_aclk);
      got = idx ? rq1_tready : rq0_tready;
    end
    chk("send_accept", got, 1);
    tick;
    if (!idx) rq0_tvalid = 1'b0;
    else      rq1_tvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g0, g1;
    logic [DW-1:0] held;
    axis_reset = 1'b1;
    rq0_tvalid = 0; rq0_we = 0; rq0_addr = '0; rq0_wdata = '0;
    rq1_tvalid = 0; rq1_we = 0; rq1_addr = '0; rq1_wdata = '0;
    rs0_tready = 1'b1; rs1_tready = 1'b1;
    repeat (3) tick;
    axis_reset = 1'b0;

    // Write then read back, starting in the first cycle out of reset.
    send(1'b0, 1'b1, 12'h010, 32'hDEAD_BEEF);
    send(1'b0, 1'b0, 12'h010, '0);
    repeat (6) tick;
    chk("wr_rd_data", last_rs0, 32'hDEAD_BEEF);

    // Tie straight after reset: requester 0 first, then 1.
    axis_reset = 1'b1;
    repeat (2) tick;
    axis_reset = 1'b0;
    gq.delete();
    rq0_tvalid = 1; rq0_we = 0; rq0_addr = 12'h001;
    rq1_tvalid = 1; rq1_we = 0; rq1_addr = 12'h002;
    g0 = 0; g1 = 0;
    for (int i = 0; i < 40 && !(g0 && g1); i++) begin
      @(negedge axis_aclk);
      g0 |= rq0_tready;
      g1 |= rq1_tready;
      tick;
      if (g0) rq0_tvalid = 1'b0;
      if (g1) rq1_tvalid = 1'b0;
    end
    repeat (6) tick;
    chk("tie_count", gq.size(), 2);
    if (gq.size() >= 2) begin
      chk("tie_first", gq[0], 0);
      chk("tie_second", gq[1], 1);
    end
    chk("tie_rs0", last_rs0, init_val(1));
    chk("tie_rs1", last_rs1, init_val(2));

    // Fairness: both requesters hold valid for 8 write transactions.
    gq.delete();
    rq0_tvalid = 1; rq0_we = 1; rq0_addr = 12'h020; rq0_wdata = $urandom;
    rq1_tvalid = 1; rq1_we = 1; rq1_addr = 12'h021; rq1_wdata = $urandom;
    for (int i = 0; i < 100 && gq.size() < 8; i++) tick;
    rq0_tvalid = 0; rq1_tvalid = 0;
    chk("fair_count", gq.size(), 8);
    for (int i = 0; i < 8 && i < gq.size(); i++) chk("fair_order", gq[i], i % 2);
    repeat (4) tick;

    // Backpressure on response channel 1 with requester 0 waiting.
    rs1_tready = 1'b0;
    send(1'b1, 1'b0, 12'h005, '0);
    rq0_tvalid = 1; rq0_we = 0; rq0_addr = 12'h003;
    for (int i = 0; i < 20 && !rs1_tvalid; i++) tick;
    held = rs1_tdata;
    repeat (5) tick;
    chk("bp_valid", rs1_tvalid, 1);
    chk("bp_busy", busy, 1);
    chk("bp_rq0_rdy", rq0_tready, 0);
    chk("bp_hold", rs1_tdata, init_val(5));
    chk("bp_stable", rs1_tdata, held);
    rs1_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rq0_tready) begin
        tick;
        rq0_tvalid = 1'b0;
        break;
      end
      tick;
    end
    chk("bp_rq0_released", rq0_tvalid, 0);
    repeat (6) tick;
    chk("bp_rs0", last_rs0, init_val(3));

    // Reset during the read latency cycle drops the response.
    send(1'b0, 1'b0, 12'h007, '0);
    tick;
    axis_reset = 1'b1;
    repeat (2) tick;
    axis_reset = 1'b0;
    repeat (6) tick;
    chk("rst_no_resp", last_rs0, init_val(3));

    // Randomized traffic, occasional reset and response backpressure.
    for (int i = 0; i < 1500; i++) begin
      axis_reset = ($urandom_range(0, 199) == 0);
      rq0_tvalid = ($urandom_range(0, 9) < 6);
      rq0_we     = $urandom_range(0, 1);
      rq0_addr   = AW'($urandom_range(0, 15));
      rq0_wdata  = $urandom;
      rq1_tvalid = ($urandom_range(0, 9) < 6);
      rq1_we     = $urandom_range(0, 1);
      rq1_addr   = AW'($urandom_range(0, 15));
      rq1_wdata  = $urandom;
      rs0_tready = ($urandom_range(0, 9) < 7);
      rs1_tready = ($urandom_range(0, 9) < 7);
      tick;
    end
    axis_reset = 0; rq0_tvalid = 0; rq1_tvalid = 0;
    rs0_tready = 1; rs1_tready = 1;
    repeat (8) tick;
    chk("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_WIDTH, 12, memory word address width.
REQ-002 Parameters SHALL be (name, default, meaning): DATA_WIDTH, 32, memory word width.
REQ-003 Ports SHALL be (name direction width meaning), one clock; reset is synchronous and active-high:
- axis_aclk  in  1  sole clock, all logic on rising edge
- axis_reset  in  1  synchronous active-high reset
- rq0_tvalid / rq1_tvalid  in  1  request N valid
- rq0_tready / rq1_tready  out  1  request N accepted this cycle
- rq0_we / rq1_we  in  1  1 = write, 0 = read
- rq0_addr / rq1_addr  in  ADDR_WIDTH  word address
- rq0_wdata / rq1_wdata  in  DATA_WIDTH  write data
- rs0_tvalid / rs1_tvalid  out  1  read response N valid
- rs0_tready / rs1_tready  in  1  requester N takes response
- rs0_tdata / rs1_tdata  out  DATA_WIDTH  read data
- mem_wr_en  out  1  single-cycle write strobe to memory
- mem_rd_en  out  1  single-cycle read strobe to memory
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rd_data  in  DATA_WIDTH  memory read data, valid the cycle after mem_rd_en
- busy  out  1  high whenever state != IDLE

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-005 IDLE: if any rqN_tvalid, grant one requester, assert its rqN_tready combinationally for that cycle only, capture we/addr/wdata and grant index on the edge, go to ISSUE; else stay.
REQ-006 Arbitration SHALL be round-robin: on simultaneous valid, the requester not granted last wins; single valid requester always wins.
REQ-007 Last-grant pointer SHALL update only on acceptance; reset value points to requester 1 (requester 0 wins first tie).
REQ-008 rqN_tready SHALL be 0 in every state but IDLE and never high for both requesters.
REQ-009 ISSUE: drive mem_addr (and mem_wdata for writes) from captured values; assert mem_wr_en (write) or mem_rd_en (read) for exactly one cycle; write -> IDLE, read -> WAIT.
REQ-010 mem_wr_en and mem_rd_en SHALL never be high together and SHALL be 0 outside ISSUE.
REQ-011 WAIT: register mem_rd_data into the response register at the end of the cycle; go to RESP.
REQ-012 RESP: assert rsN_tvalid only for the granted requester with rsN_tdata = captured data; hold both stable until rsN_tready; on rsN_tvalid && rsN_tready go to IDLE.
REQ-013 Writes SHALL produce no response; rsN_tvalid SHALL stay 0 for write transactions.
REQ-014 Latency: request accepted at edge T -> mem strobe in cycle T+1; read response valid from cycle T+3; next acceptance no earlier than cycle T+2 (write) or cycle after response handshake (read).
REQ-015 Under continuous valid from both requesters, grants SHALL alternate 0,1,0,1 with no starvation.
REQ-016 Requester deasserting rqN_tvalid before acceptance SHALL cancel nothing internal (no state change).
REQ-017 rsN_tdata for the non-granted requester SHALL be 0.

Reset
REQ-018 axis_reset sampled high SHALL force state IDLE, last-grant = 1, all outputs 0 (tready, tvalid, tdata, mem_*, busy) on the next edge.
REQ-019 Reset mid-transaction SHALL abandon it: a pending read response is dropped; a write not yet strobed is not issued.
REQ-020 First acceptance after reset deassertion SHALL be possible in the first cycle reset is low.

Verification
REQ-021 Directed scenarios:
- Write then read: rq0 write addr 0x010 data 0xDEADBEEF, then rq0 read 0x010 -> mem_wr_en one cycle at T+1 with addr 0x010; rs0_tdata = 0xDEADBEEF valid at T'+3.
- Tie: rq0 and rq1 read 0x001/0x002 same cycle after reset -> rq0 granted first, rq1 next; rs0 then rs1 responses, correct data each.
- Fairness: both held valid for 8 transactions -> grant order 0,1,0,1,0,1,0,1.
- Backpressure: rs1_tready low 5 cycles during RESP -> rs1_tvalid and rs1_tdata held stable, rq0_tready stays 0, busy = 1.
- Reset mid-read: axis_reset high in WAIT -> next cycle all outputs 0, no rs tvalid ever issued for that read.
- Strobe exclusivity: random traffic 1000 cycles -> mem_wr_en & mem_rd_en never both 1; each strobe exactly one cycle wide.
